// File: rtl/skid_stage_reg.sv
// Registered valid/ready stage with a 2-entry skid buffer; every port-to-port path is broken by a flop.
// Optional backpressure counter (stall_cnt) is compiled in with SKID_STALL_CNT_EN.
module skid_stage_reg #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SKID_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_data_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and data-path selection; data registers load only on a fire.
    always_comb begin
        state_d     = state_q;
        main_data_d = out_data;
        skid_data_d = skid_data_q;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = in_data;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = in_data;
                end else if (in_fire) begin
                    skid_data_d = in_data;
                    state_d     = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are flopped from the next state so out_ready never reaches in_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_data    <= '0;
            skid_data_q <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data    <= main_data_d;
            skid_data_q <= skid_data_d;
            out_valid   <= (state_d != EMPTY);
            in_ready    <= (state_d != FULL);
        end
    end

`ifdef SKID_STALL_CNT_EN
    // Saturating count of cycles the consumer holds off a valid word.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`else
    // Counter absent; the width parameter is kept so both builds share one interface.
    if (STALL_CNT_W == 0) begin : g_no_stall_cnt
    end
`endif

endmodule
